// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_sub_pkg
// Purpose : Shared definitions for the bit-serial subtractor.
//           - DEFAULT_WIDTH : default operand/result width
//           - state_t       : controller state encoding (IDLE, RUN, DONE)
// Revision: 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : full_subtractor
// Purpose : One-bit full subtractor computing x - y - bin.
// Ports   : x   in  minuend bit
//           y   in  subtrahend bit
//           bin in  borrow in
//           d   out difference bit
//           bo  out borrow out
// Revision: 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  // Borrow when x is 0 and y is 1, or when x equals y and a borrow comes in.
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : serial_subtractor
// Purpose : Bit-serial unsigned subtractor, LSB first, one bit per clock.
//           Computes (a - b) mod 2^WIDTH with valid/ready handshakes on both
//           the operand and the result side.
// Ports   : clk         in  clock, rising edge
//           rst_n       in  synchronous active-low reset
//           start_valid in  operand pair offered
//           start_ready out block can accept an operand pair (IDLE)
//           a, b        in  minuend / subtrahend, unsigned
//           res_valid   out result outputs valid (DONE)
//           res_ready   in  consumer takes the result
//           diff        out (a - b) mod 2^WIDTH
//           bout        out final borrow, 1 iff a < b
//           zero        out 1 iff diff == 0
// Revision: 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bo_bit;
  logic             accept;

  full_subtractor u_fs (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (borrow),
    .d   (d_bit),
    .bo  (bo_bit)
  );

  // Difference bits enter at the MSB so that after WIDTH steps the first
  // (LSB) difference bit has arrived at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d_bit;
    end else begin : g_res_wn
      assign res_next = {d_bit, res_sh[WIDTH-1:1]};
    end
  endgenerate

  assign accept = (state == IDLE) && start_valid;

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      borrow <= bo_bit;
      cnt    <= cnt + CW'(1);
    end
  end

  assign diff = res_sh;
  assign bout = borrow;
  assign zero = (res_sh == '0);

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_subtractor
// Purpose : Self-checking bench for serial_subtractor (WIDTH = 8). A
//           transaction-level model predicts handshake flags and results
//           every cycle; directed cases pin literal results and latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;

  int compared   = 0;
  int mismatched = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff        (diff),
    .bout        (bout),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model: an operation is pending from acceptance until
  // the result handshake; the result is due W edges after acceptance.
  // --------------------------------------------------------------------------
  bit           m_live    = 0;
  bit           m_pending = 0;
  bit           m_done    = 0;
  int           m_edges   = 0;
  logic [W-1:0] m_diff;
  bit           m_bout;
  bit           m_zero;

  always @(posedge clk) begin
    m_live = 1;
    if (!rst_n) begin
      m_pending = 0;
      m_done    = 0;
    end else if (!m_pending) begin
      if (start_valid) begin
        m_pending = 1;
        m_done    = 0;
        m_edges   = 0;
        m_diff    = W'(int'(a) - int'(b));
        m_bout    = (a < b);
        m_zero    = (a == b);
      end
    end else if (!m_done) begin
      m_edges++;
      if (m_edges == W) m_done = 1;
    end else if (res_ready) begin
      m_pending = 0;
      m_done    = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("start_ready", start_ready, !m_pending);
      check("res_valid", res_valid, m_done);
      if (m_done) begin
        check("diff", diff, m_diff);
        check("bout", bout, m_bout);
        check("zero", zero, m_zero);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed operation with literal expectations. Called at a negedge while
  // the DUT is idle; returns at the negedge after the result handshake.
  // --------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input int hold, input bit toggle,
                        input logic [W-1:0] ed, input bit eb, input bit ez);
    int lat;
    res_ready   = (hold == 0);
    a           = ia;
    b           = ib;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      if (toggle) begin
        start_valid = ~start_valid;
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start_valid = 1'b0;
    check("latency", lat, W);
    check("lit_diff", diff, ed);
    check("lit_bout", bout, eb);
    check("lit_zero", zero, ez);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", res_valid, 1'b1);
      check("hold_diff", diff, ed);
      check("hold_bout", bout, eb);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_ready", start_ready, 1'b1);
    check("post_valid", res_valid, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", start_ready, 1'b1);
    check("rst_valid", res_valid, 1'b0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 1'b0);
    check("rst_zero", zero, 1'b1);
    rst_n = 1'b1;

    run_op(8'h35, 8'h12, 0, 0, 8'h23, 1'b0, 1'b0);
    run_op(8'h12, 8'h35, 0, 0, 8'hDD, 1'b1, 1'b0);
    run_op(8'h7F, 8'h7F, 0, 0, 8'h00, 1'b0, 1'b1);
    run_op(8'h00, 8'h01, 0, 0, 8'hFF, 1'b1, 1'b0);
    run_op(8'hFF, 8'h00, 0, 0, 8'hFF, 1'b0, 1'b0);
    // Back-pressure: result held for 5 cycles.
    run_op(8'hA0, 8'h0B, 5, 0, 8'h95, 1'b0, 1'b0);
    // New operands offered during RUN must be ignored.
    run_op(8'h9C, 8'h47, 0, 1, 8'h55, 1'b0, 1'b0);

    // Reset on the 4th RUN edge discards the operation.
    a = 8'h55; b = 8'h22; start_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", start_ready, 1'b1);
    check("midrst_valid", res_valid, 1'b0);
    check("midrst_diff", diff, 0);
    rst_n = 1'b1;
    run_op(8'h80, 8'h81, 0, 0, 8'hFF, 1'b1, 1'b0);

    // Randomized traffic, with occasional resets, checked by the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      start_valid = $urandom_range(0, 1) == 1;
      res_ready   = $urandom_range(0, 2) != 0;
      a           = W'($urandom);
      b           = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port start_valid  input  1  requester offers an operand pair.
REQ-005 The block SHALL have port start_ready  output  1  block can accept an operand pair.
REQ-006 The block SHALL have port a  input  WIDTH  minuend, unsigned.
REQ-007 The block SHALL have port b  input  WIDTH  subtrahend, unsigned.
REQ-008 The block SHALL have port res_valid  output  1  result outputs are valid.
REQ-009 The block SHALL have port res_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 The block SHALL have port bout  output  1  final borrow; 1 iff a < b.
REQ-012 The block SHALL have port zero  output  1  1 iff diff == 0.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE, start_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-015 An operand pair SHALL be accepted on a rising edge with start_valid && start_ready; a and b are sampled only at that edge.
REQ-016 On acceptance: a and b load into shift registers, borrow register clears to 0, bit counter clears to 0, state moves IDLE -> RUN.
REQ-017 Each RUN cycle SHALL perform one full-subtract step on the LSBs of both shift registers and the borrow register, then shift both right by one, shift the difference bit into the result register MSB, update borrow, and increment the counter.
REQ-018 After exactly WIDTH RUN edges, state SHALL move RUN -> DONE, so res_valid rises on the WIDTH-th rising edge after the accepting edge.
REQ-019 In DONE, res_valid SHALL be 1, and diff, bout and zero SHALL hold stable until the handshake.
REQ-020 DONE -> IDLE SHALL occur on the edge with res_valid && res_ready; no new operand is accepted on that same edge.
REQ-021 start_valid asserted during RUN or DONE SHALL be ignored, with no effect on the computation.
REQ-022 res_ready SHALL be ignored outside DONE.
REQ-023 bout SHALL equal the borrow register after the final step; zero SHALL be derived from the final result register.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within one operation; WIDTH=1 SHALL complete in one RUN cycle.
REQ-025 diff, bout and zero MAY change while res_valid is 0; consumers sample them only with res_valid.

Reset
REQ-026 While rst_n is 0 at a rising edge, the state SHALL become IDLE, and shift registers, result register, borrow and counter SHALL clear to 0.
REQ-027 Reset values SHALL be: start_ready=1, res_valid=0, diff=0, bout=0, zero=1 (derived from diff=0).
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation with no partial result presented.

Structure
REQ-029 A shared package serial_sub_pkg SHALL hold the FSM state enum typedef and the default WIDTH constant.
REQ-030 A combinational sub-module full_subtractor (inputs x, y, bin; outputs d = x^y^bin, bo = (~x&y) | (~(x^y)&bin)) SHALL be instantiated once for the per-bit step.
REQ-031 The target size of the RTL SHALL be 120-400 lines, excluding the package.

Verification
REQ-032 WIDTH=8, a=0x35, b=0x12, res_ready=1 -> res_valid on the 8th edge after acceptance, diff=0x23, bout=0, zero=0.
REQ-033 a=0x12, b=0x35 -> diff=0xDD, bout=1, zero=0.
REQ-034 a=0x7F, b=0x7F -> diff=0x00, bout=0, zero=1; a=0x00, b=0x01 -> diff=0xFF, bout=1.
REQ-035 Hold res_ready=0 for 5 cycles in DONE -> res_valid stays 1 with outputs stable; release -> IDLE and start_ready=1 next cycle.
REQ-036 Assert rst_n=0 on the 4th RUN cycle -> next edge gives IDLE, res_valid=0, diff=0, start_ready=1; a fresh operation then completes correctly.
REQ-037 Toggle start_valid with new operands during RUN -> the original result is unchanged and the new operands are not accepted.
